ae18_stkctl: RTL and testbench

- Hardware return-stack controller for the AE18 core.
- Owns the stack pointer, the overflow/underflow flags and the top-of-stack (TOS) view.
- Acts as the sole initiator on the write/read ports of the AE18 synchronous RAM block: drives write data, write address, write enable and read address, and consumes read data.
- Sits between the core's CALL/RETURN/PUSH/POP decode and the stack RAM.

---
 rtl/ae18_stkctl_if.sv | 28 ++
 rtl/ae18_stkctl.sv | 104 ++++++++++
 tb/tb_ae18_stkctl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ae18_stkctl_if.sv
// Stack RAM port bundle between the AE18 return-stack controller (master)
// and the synchronous stack RAM (slave).
interface ae18_stkctl_if #(
  parameter int ISIZ = 24,
  parameter int SSIZ = 5
);
  logic [ISIZ-1:0] m_wdat;
  logic [SSIZ-1:0] m_wadr;
  logic            m_we;
  logic [SSIZ-1:0] m_radr;
  logic [ISIZ-1:0] m_rdat;

  modport master (
    output m_wdat,
    output m_wadr,
    output m_we,
    output m_radr,
    input  m_rdat
  );

  modport slave (
    input  m_wdat,
    input  m_wadr,
    input  m_we,
    input  m_radr,
    output m_rdat
  );
endinterface

// File: rtl/ae18_stkctl.sv
// AE18 hardware return-stack controller: pointer, sticky full/unf flags, TOS view.
// Define AE18_STKTRAP_EN to get a one-cycle trap pulse and stack reset on any fault.
module ae18_stkctl #(
  parameter int ISIZ = 24,
  parameter int SSIZ = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            tos_we,
  input  logic [ISIZ-1:0] din,
  input  logic            clr,
  output logic [ISIZ-1:0] tos,
  output logic [SSIZ-1:0] ptr,
  output logic            full,
  output logic            unf,
  output logic            trap,
  ae18_stkctl_if.master   ram
);

  localparam logic [SSIZ-1:0] PMAX = '1;

  logic [SSIZ-1:0] ptr_nx;
  logic [SSIZ-1:0] wadr;
  logic            we;
  logic            ovf;
  logic            udf;
  logic            sel_q;
  logic            empty;
  logic            at_top;

  assign empty  = (ptr == '0);
  assign at_top = (ptr == PMAX);

  // Command decode; slot 0 is the empty marker and is never written.
  always_comb begin
    ptr_nx = ptr;
    wadr   = ptr;
    we     = 1'b0;
    ovf    = 1'b0;
    udf    = 1'b0;
    if (push && pop && !empty) begin
      we = 1'b1;
    end else if (push) begin
      if (at_top) begin
        ovf = 1'b1;
      end else begin
        we     = 1'b1;
        wadr   = ptr + 1'b1;
        ptr_nx = ptr + 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        udf = 1'b1;
      end else begin
        ptr_nx = ptr - 1'b1;
      end
    end else if (tos_we && !empty) begin
      we = 1'b1;
    end
`ifdef AE18_STKTRAP_EN
    if (ovf || udf) begin
      ptr_nx = '0;
    end
`endif
  end

  // Read address follows the next pointer so m_rdat holds mem[ptr] after every edge.
  assign ram.m_radr = ptr_nx;
  assign ram.m_wadr = wadr;
  assign ram.m_wdat = din;
  assign ram.m_we   = we & rst;

  assign tos = sel_q ? ram.m_rdat : '0;

  // A fault in the same cycle as clr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      full  <= 1'b0;
      unf   <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      ptr   <= ptr_nx;
      sel_q <= (ptr_nx != '0);
      full  <= ovf | (full & ~clr);
      unf   <= udf | (unf & ~clr);
    end
  end

`ifdef AE18_STKTRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap <= 1'b0;
    end else begin
      trap <= ovf | udf;
    end
  end
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_ae18_stkctl.sv
// Self-checking bench for ae18_stkctl: queue-based stack model, write-first RAM,
// per-cycle compare process plus directed literal checks.
module tb_ae18_stkctl;
  localparam int ISIZ = 24;
  localparam int SSIZ = 5;
  localparam int PMAX = 31;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            push = 1'b0;
  logic            pop = 1'b0;
  logic            tos_we = 1'b0;
  logic            clr = 1'b0;
  logic [ISIZ-1:0] din = '0;
  logic [ISIZ-1:0] tos;
  logic [SSIZ-1:0] ptr;
  logic            full;
  logic            unf;
  logic            trap;

  int checks = 0;
  int errors = 0;

  ae18_stkctl_if #(.ISIZ(ISIZ), .SSIZ(SSIZ)) ram_bus ();

  ae18_stkctl #(.ISIZ(ISIZ), .SSIZ(SSIZ)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .tos_we (tos_we),
    .din    (din),
    .clr    (clr),
    .tos    (tos),
    .ptr    (ptr),
    .full   (full),
    .unf    (unf),
    .trap   (trap),
    .ram    (ram_bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, write-first on an address collision.
  logic [ISIZ-1:0] mem [0:PMAX];
  always @(posedge clk) begin
    if (ram_bus.m_we) mem[ram_bus.m_wadr] <= ram_bus.m_wdat;
    if (ram_bus.m_we && ram_bus.m_wadr == ram_bus.m_radr) ram_bus.m_rdat <= ram_bus.m_wdat;
    else ram_bus.m_rdat <= mem[ram_bus.m_radr];
  end

  // Reference model: the stack is a queue, its size is the pointer.
  logic [ISIZ-1:0] q[$];
  bit mFull = 0;
  bit mUnf = 0;
  bit mTrap = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      mFull = 0;
      mUnf = 0;
      mTrap = 0;
    end else begin
      bit ovf;
      bit udf;
      ovf = 0;
      udf = 0;
      if (push && pop && q.size() > 0) q[q.size()-1] = din;
      else if (push) begin
        if (q.size() < PMAX) q.push_back(din);
        else ovf = 1;
      end else if (pop) begin
        if (q.size() > 0) void'(q.pop_back());
        else udf = 1;
      end else if (tos_we && q.size() > 0) q[q.size()-1] = din;
      if (ovf) mFull = 1; else if (clr) mFull = 0;
      if (udf) mUnf = 1; else if (clr) mUnf = 0;
`ifdef AE18_STKTRAP_EN
      mTrap = ovf | udf;
      if (ovf | udf) q.delete();
`else
      mTrap = 0;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Mid-cycle compare of state and RAM write port against the model.
  always @(negedge clk) begin
    int n;
    bit expWe;
    logic [31:0] expAdr;
    n = q.size();
    expWe = 0;
    expAdr = 0;
    if (rst) begin
      if (push && pop && n > 0) begin expWe = 1; expAdr = n; end
      else if (push) begin
        if (n < PMAX) begin expWe = 1; expAdr = n + 1; end
      end else if (!pop && tos_we && n > 0) begin expWe = 1; expAdr = n; end
    end
    checkOutput("cyc_ptr", ptr, n);
    checkOutput("cyc_tos", tos, (n == 0) ? 32'h0 : q[n-1]);
    checkOutput("cyc_full", full, mFull);
    checkOutput("cyc_unf", unf, mUnf);
    checkOutput("cyc_trap", trap, mTrap);
    checkOutput("cyc_we", ram_bus.m_we, expWe);
    if (expWe) begin
      checkOutput("cyc_wadr", ram_bus.m_wadr, expAdr);
      checkOutput("cyc_wdat", ram_bus.m_wdat, din);
    end
  end

  task automatic applyStimulus(input bit p, input bit po, input bit tw, input logic [ISIZ-1:0] d, input bit c);
    push = p;
    pop = po;
    tos_we = tw;
    din = d;
    clr = c;
    @(posedge clk);
    #1;
    push = 0;
    pop = 0;
    tos_we = 0;
    clr = 0;
  endtask

  task automatic fillStack();
    for (int i = 1; i <= PMAX; i++) applyStimulus(1, 0, 0, 24'h000100 + i[23:0], 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1;
    checkOutput("rst_ptr", ptr, 0);
    checkOutput("rst_tos", tos, 0);
    checkOutput("rst_full", full, 0);

    fillStack();
    checkOutput("fill_ptr", ptr, 31);
    checkOutput("fill_tos", tos, 32'h00011F);

    for (int i = 30; i >= 0; i--) begin
      applyStimulus(0, 1, 0, '0, 0);
      checkOutput("drain_tos", tos, (i == 0) ? 32'h0 : (32'h100 + i));
      checkOutput("drain_ptr", ptr, i);
    end
    checkOutput("drain_full", full, 0);
    checkOutput("drain_unf", unf, 0);

    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("udf_unf", unf, 1);
    checkOutput("udf_ptr", ptr, 0);
    checkOutput("udf_tos", tos, 0);
`ifdef AE18_STKTRAP_EN
    checkOutput("udf_trap", trap, 1);
`endif
    applyStimulus(0, 1, 0, '0, 1);
    checkOutput("udf_clr_pop_unf", unf, 1);
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("udf_clr_unf", unf, 0);

    applyStimulus(1, 0, 0, 24'h000111, 0);
    applyStimulus(1, 0, 0, 24'h000222, 0);
    checkOutput("rep_ptr0", ptr, 2);
    checkOutput("rep_tos0", tos, 32'h000222);
    applyStimulus(1, 1, 0, 24'h000333, 0);
    checkOutput("rep_ptr1", ptr, 2);
    checkOutput("rep_tos1", tos, 32'h000333);
    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("rep_entry1", tos, 32'h000111);
    applyStimulus(0, 0, 1, 24'h000444, 0);
    checkOutput("tos_we_tos", tos, 32'h000444);
    checkOutput("tos_we_ptr", ptr, 1);
    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("rep_empty", ptr, 0);

    push = 1; din = 24'hA5A5A5;
    #1 checkOutput("b2b_wadr_a", ram_bus.m_wadr, 1);
    @(posedge clk); #1 push = 0;
    checkOutput("b2b_tos_a", tos, 32'hA5A5A5);
    checkOutput("b2b_ptr_a", ptr, 1);
    pop = 1;
    @(posedge clk); #1 pop = 0;
    checkOutput("b2b_tos_pop", tos, 0);
    checkOutput("b2b_ptr_pop", ptr, 0);
    push = 1; din = 24'h5A5A5A;
    #1 checkOutput("b2b_wadr_b", ram_bus.m_wadr, 1);
    @(posedge clk); #1 push = 0;
    checkOutput("b2b_tos_b", tos, 32'h5A5A5A);
    checkOutput("b2b_ptr_b", ptr, 1);
    applyStimulus(0, 1, 0, '0, 0);

    fillStack();
    applyStimulus(1, 0, 0, 24'hABCDEF, 0);
    checkOutput("ovf_full", full, 1);
`ifdef AE18_STKTRAP_EN
    checkOutput("ovf_trap", trap, 1);
    checkOutput("ovf_ptr", ptr, 0);
    applyStimulus(0, 0, 0, '0, 0);
    checkOutput("ovf_trap_pulse", trap, 0);
`else
    checkOutput("ovf_ptr", ptr, 31);
    checkOutput("ovf_tos", tos, 32'h00011F);
    checkOutput("ovf_trap", trap, 0);
`endif
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("ovf_clr_full", full, 0);

    applyStimulus(1, 0, 0, 24'h000888, 0);
    push = 1; din = 24'h000999;
    #2 rst = 0;
    #1;
    checkOutput("mid_rst_ptr", ptr, 0);
    checkOutput("mid_rst_full", full, 0);
    checkOutput("mid_rst_unf", unf, 0);
    checkOutput("mid_rst_tos", tos, 0);
    checkOutput("mid_rst_we", ram_bus.m_we, 0);
    @(posedge clk); #1;
    push = 0;
    rst = 1;
    applyStimulus(0, 0, 0, '0, 0);
    checkOutput("post_rst_ptr", ptr, 0);
    checkOutput("post_rst_tos", tos, 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
